// File: rtl/extram_pkg.sv
// Shared constants for the external-RAM bus controller: FSM encodings,
// slave indices and the address-region decode layout.
package extram_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int SLV_SD   = 0;
  localparam int SLV_CDDA = 1;
  localparam int SLV_IDE  = 2;

  localparam int          DEC_IDE_BIT   = 12;
  localparam int          DEC_SUB_BIT   = 11;
  localparam logic [15:0] UNMAPPED_MASK = 16'hE000;

  function automatic logic [31:0] zext8(input logic [7:0] d);
    return {24'h00_0000, d};
  endfunction

endpackage

// File: rtl/extram_bus_ctrl_chk.sv
// Protocol checker for extram_bus_ctrl: slave selects stay one-hot and an
// error pulse only ever accompanies a completed (non-stalled) access.
module extram_bus_ctrl_chk (
  input logic       clk,
  input logic       reset_,
  input logic [2:0] slv_cs,
  input logic       cpu_wait,
  input logic       cpu_buserr
);

  a_cs_onehot: assert property (@(posedge clk) disable iff (!reset_)
    $onehot0(slv_cs));

  a_err_done: assert property (@(posedge clk) disable iff (!reset_)
    cpu_buserr |-> (!cpu_wait && (slv_cs == 3'b000)));

endmodule

// File: rtl/extram_decode.sv
// Combinational CPU address decode into a one-hot slave select plus an
// unmapped flag; the select is all-zero whenever the address is unmapped.
module extram_decode
  import extram_pkg::*;
(
  input  logic [15:0] i_a,
  output logic [2:0]  o_sel,
  output logic        o_unmapped
);

  logic w_unmapped;

  // Region decode: IDE owns the upper 4 KiB, sdcard/cdda split the lower half
  always_comb begin
    w_unmapped = |(i_a & UNMAPPED_MASK);
    o_sel      = 3'b000;
    if (w_unmapped) begin
      o_sel = 3'b000;
    end else if (i_a[DEC_IDE_BIT]) begin
      o_sel[SLV_IDE] = 1'b1;
    end else if (i_a[DEC_SUB_BIT]) begin
      o_sel[SLV_CDDA] = 1'b1;
    end else begin
      o_sel[SLV_SD] = 1'b1;
    end
    o_unmapped = w_unmapped;
  end

endmodule

// File: rtl/extram_bus_ctrl.sv
// CPU external-RAM bus sequencer: registered decode, one-hot slave select,
// per-access wait handshake and bus timeout with error reporting.
module extram_bus_ctrl
  import extram_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [15:0] cpu_a,
  input  logic [31:0] cpu_d_in,
  output logic [31:0] cpu_d_out,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_wait,
  output logic        cpu_buserr,
  output logic [15:0] slv_a,
  output logic [31:0] slv_d_out,
  output logic        slv_oe,
  output logic [3:0]  slv_wstrb,
  output logic [2:0]  slv_cs,
  input  logic [31:0] slv_d_ide,
  input  logic [7:0]  slv_d_sd,
  input  logic [7:0]  slv_d_cdda,
  input  logic [2:0]  slv_wait
);

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_sel;
  logic [2:0]  r_slv_cs;
  logic [9:0]  r_cnt;
  logic        r_buserr;
  logic [31:0] r_d_out;
  logic [15:0] r_a;
  logic [31:0] r_wd;
  logic        r_oe;
  logic [3:0]  r_wstrb;

  logic [2:0]  w_sel;
  logic        w_unmapped;
  logic        w_sel_wait;
  logic [31:0] w_rdata;

  extram_decode u_decode (
    .i_a        (cpu_a),
    .o_sel      (w_sel),
    .o_unmapped (w_unmapped)
  );

  // Selected slave's wait and read data, narrow slaves zero-extended
  always_comb begin
    w_sel_wait = |(slv_wait & r_sel);
    w_rdata    = 32'h0000_0000;
    if (r_sel[SLV_IDE]) begin
      w_rdata = slv_d_ide;
    end else if (r_sel[SLV_CDDA]) begin
      w_rdata = zext8(slv_d_cdda);
    end else if (r_sel[SLV_SD]) begin
      w_rdata = zext8(slv_d_sd);
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  // Access FSM with address latch, timeout counter and read-data capture
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state  <= ST_IDLE;
      r_sel    <= 3'b000;
      r_slv_cs <= 3'b000;
      r_cnt    <= 10'd0;
      r_buserr <= 1'b0;
      r_d_out  <= 32'h0000_0000;
      r_a      <= 16'h0000;
      r_wd     <= 32'h0000_0000;
      r_oe     <= 1'b0;
      r_wstrb  <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_buserr <= 1'b0;
          if (cpu_cs) begin
            r_a     <= cpu_a;
            r_wd    <= cpu_d_in;
            r_oe    <= cpu_oe;
            r_wstrb <= cpu_oe ? 4'b0000 : cpu_wstrb;
            r_sel   <= w_sel;
            if (w_unmapped) begin
              r_state  <= ST_DONE;
              r_buserr <= 1'b1;
              if (cpu_oe) begin
                r_d_out <= ERR_DATA;
              end
            end else begin
              r_state <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          r_cnt <= 10'd0;
          if (cpu_cs) begin
            r_slv_cs <= r_sel;
            r_state  <= ST_ACTIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          // A CPU abort outranks both completion and timeout
          if (!cpu_cs) begin
            r_slv_cs <= 3'b000;
            r_state  <= ST_IDLE;
          end else if (!w_sel_wait) begin
            if (r_oe) begin
              r_d_out <= w_rdata;
            end
            r_slv_cs <= 3'b000;
            r_state  <= ST_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_slv_cs <= 3'b000;
            r_d_out  <= ERR_DATA;
            r_buserr <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        ST_DONE: begin
          r_buserr <= 1'b0;
          if (!cpu_cs) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_slv_cs <= 3'b000;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Gated by reset_ so the stall releases the instant reset asserts
  assign cpu_wait   = reset_ & cpu_cs & (r_state != ST_DONE);
  assign cpu_buserr = r_buserr;
  assign cpu_d_out  = r_d_out;
  assign slv_a      = r_a;
  assign slv_d_out  = r_wd;
  assign slv_oe     = r_oe;
  assign slv_wstrb  = r_wstrb;
  assign slv_cs     = r_slv_cs;

endmodule
